// File: rtl/receiver_core.sv
// UART receive stage: two-flop input synchroniser, start-bit glitch check,
// LSB-first data sampling at bit centres, and stop-bit framing check.
module receiver_core #(
  parameter int DATA_WIDTH          = 8,
  parameter int BIT_COUNTER_WIDTH   = 3,
  parameter int CLOCK_COUNTER_WIDTH = 9,
  parameter int CLOCKS_PER_BIT      = 434
) (
  input  logic                  i_clock,
  input  logic                  i_resetL,
  input  logic                  i_RX,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_frame_error,
  output logic                  o_busy
);

  // state | meaning
  // IDLE  | line idle, waiting for a low rx_s
  // START | waiting half a bit to confirm the start bit
  // DATA  | sampling data bits at bit centres
  // STOP  | sampling the stop bit at its centre
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [CLOCK_COUNTER_WIDTH-1:0] HALF_M1  = CLOCK_COUNTER_WIDTH'(CLOCKS_PER_BIT/2 - 1);
  localparam logic [CLOCK_COUNTER_WIDTH-1:0] BIT_M1   = CLOCK_COUNTER_WIDTH'(CLOCKS_PER_BIT - 1);
  localparam logic [BIT_COUNTER_WIDTH-1:0]   LAST_BIT = BIT_COUNTER_WIDTH'(DATA_WIDTH - 1);

  state_t                         state, state_next;
  logic                           rx_m, rx_s;
  logic [CLOCK_COUNTER_WIDTH-1:0] clk_cnt;
  logic [BIT_COUNTER_WIDTH-1:0]   bit_cnt;
  logic [DATA_WIDTH-1:0]          shreg;

  logic half_done, bit_done, last_bit;
  logic cnt_clr, cnt_inc, bit_clr, bit_inc, shift_en, valid_set, err_set;

  assign half_done = (clk_cnt == HALF_M1);
  assign bit_done  = (clk_cnt == BIT_M1);
  assign last_bit  = (bit_cnt == LAST_BIT);

  // Synchroniser resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge i_clock or negedge i_resetL) begin
    if (!i_resetL) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_RX;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge i_clock or negedge i_resetL) begin
    if (!i_resetL) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (!rx_s) state_next = START;
      START: if (half_done) state_next = rx_s ? IDLE : DATA;
      DATA:  if (bit_done && last_bit) state_next = STOP;
      STOP:  if (bit_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    bit_clr   = 1'b0;
    bit_inc   = 1'b0;
    shift_en  = 1'b0;
    valid_set = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        bit_clr = 1'b1;
      end
      START: begin
        if (half_done) cnt_clr = 1'b1;
        else           cnt_inc = 1'b1;
      end
      DATA: begin
        if (bit_done) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (last_bit) bit_clr = 1'b1;
          else          bit_inc = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      STOP: begin
        if (bit_done) begin
          cnt_clr   = 1'b1;
          valid_set = rx_s;
          err_set   = !rx_s;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: begin
        cnt_clr = 1'b1;
        bit_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_resetL) begin
    if (!i_resetL) begin
      clk_cnt       <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      o_data        <= '0;
      o_valid       <= 1'b0;
      o_frame_error <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      if (cnt_clr)      clk_cnt <= '0;
      else if (cnt_inc) clk_cnt <= clk_cnt + 1'b1;
      if (bit_clr)      bit_cnt <= '0;
      else if (bit_inc) bit_cnt <= bit_cnt + 1'b1;
      if (shift_en)     shreg   <= {rx_s, shreg[DATA_WIDTH-1:1]};
      if (valid_set)    o_data  <= shreg;
      o_valid       <= valid_set;
      o_frame_error <= err_set;
      o_busy        <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_receiver_core.sv
// Directed bench for receiver_core: a fast instance (16 clocks/bit) for the
// functional cases and a default-parameter instance for a full-rate frame.
module tb_receiver_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic [7:0] a_data, b_data;
  logic       a_valid, a_err, a_busy;
  logic       b_valid, b_err, b_busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int a_vcnt = 0, a_ecnt = 0, a_vcyc = 0;
  int b_vcnt = 0, b_ecnt = 0;
  int excl_viol = 0;
  logic prev_a = 1'b0;
  logic [7:0] a_words[$];
  logic [7:0] b_last = 8'h00;

  always #5 clk = ~clk;

  receiver_core #(
    .DATA_WIDTH(8), .BIT_COUNTER_WIDTH(3), .CLOCK_COUNTER_WIDTH(5), .CLOCKS_PER_BIT(16)
  ) dut_a (
    .i_clock(clk), .i_resetL(rst_n), .i_RX(rx_a),
    .o_data(a_data), .o_valid(a_valid), .o_frame_error(a_err), .o_busy(a_busy)
  );

  receiver_core dut_b (
    .i_clock(clk), .i_resetL(rst_n), .i_RX(rx_b),
    .o_data(b_data), .o_valid(b_valid), .o_frame_error(b_err), .o_busy(b_busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (a_valid) begin
      a_vcnt <= a_vcnt + 1;
      a_vcyc <= cyc;
      a_words.push_back(a_data);
    end
    if (a_err) a_ecnt <= a_ecnt + 1;
    if ((a_valid && a_err) || ((a_valid || a_err) && prev_a)) excl_viol <= excl_viol + 1;
    prev_a <= a_valid || a_err;
    if (b_valid) begin
      b_vcnt <= b_vcnt + 1;
      b_last <= b_data;
    end
    if (b_err) b_ecnt <= b_ecnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every driving task starts and ends 1 time unit after a rising edge.
  task automatic send_bit(input bit sel, input logic v, input int n);
    if (sel) rx_b = v;
    else     rx_a = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input logic stop, input int cpb);
    if (!sel) fall_cyc = cyc;
    send_bit(sel, 1'b0, cpb);
    for (int i = 0; i < 8; i++) send_bit(sel, d[i], cpb);
    send_bit(sel, stop, cpb);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int v0, e0, n0;

  initial begin
    // Reset state
    idle(3);
    check("rst_data",  {24'h0, a_data}, 32'h00);
    check("rst_valid", {31'h0, a_valid}, 32'h0);
    check("rst_err",   {31'h0, a_err}, 32'h0);
    check("rst_busy",  {31'h0, a_busy}, 32'h0);
    rst_n = 1'b1;
    idle(4);

    // 1: good frame 0xA5 and its latency from the falling edge
    send_frame(1'b0, 8'hA5, 1'b1, 16);
    idle(20);
    check("t1_vcnt", a_vcnt, 1);
    check("t1_ecnt", a_ecnt, 0);
    check("t1_data", {24'h0, a_data}, 32'hA5);
    check("t1_latency", a_vcyc - fall_cyc, 155);
    check("t1_busy_idle", {31'h0, a_busy}, 32'h0);

    // 2: 4-cycle glitch is rejected
    v0 = a_vcnt; e0 = a_ecnt;
    send_bit(1'b0, 1'b0, 4);
    send_bit(1'b0, 1'b1, 2);
    check("t2_busy_during", {31'h0, a_busy}, 32'h1);
    idle(20);
    check("t2_busy_after", {31'h0, a_busy}, 32'h0);
    check("t2_vcnt", a_vcnt, v0);
    check("t2_ecnt", a_ecnt, e0);
    check("t2_data", {24'h0, a_data}, 32'hA5);

    // 3: framing error keeps the previous word
    v0 = a_vcnt; e0 = a_ecnt;
    send_frame(1'b0, 8'h3C, 1'b0, 16);
    rx_a = 1'b1;
    idle(40);
    check("t3_ecnt", a_ecnt, e0 + 1);
    check("t3_vcnt", a_vcnt, v0);
    check("t3_data", {24'h0, a_data}, 32'hA5);

    // 4: back-to-back frames, no idle gap
    v0 = a_vcnt; e0 = a_ecnt; n0 = a_words.size();
    send_frame(1'b0, 8'h00, 1'b1, 16);
    send_frame(1'b0, 8'hFF, 1'b1, 16);
    idle(20);
    check("t4_vcnt", a_vcnt, v0 + 2);
    check("t4_ecnt", a_ecnt, e0);
    check("t4_word0", {24'h0, a_words[n0]}, 32'h00);
    check("t4_word1", {24'h0, a_words[n0+1]}, 32'hFF);
    check("t4_data", {24'h0, a_data}, 32'hFF);

    // 5: reset during data bit 4 of 0x5A, then a clean 0x5A
    v0 = a_vcnt; e0 = a_ecnt;
    send_bit(1'b0, 1'b0, 16);
    for (int i = 0; i < 4; i++) send_bit(1'b0, (8'h5A >> i) & 1'b1, 16);
    send_bit(1'b0, 1'b1, 8);
    rst_n = 1'b0;
    #2;
    check("t5_rst_data",  {24'h0, a_data}, 32'h00);
    check("t5_rst_busy",  {31'h0, a_busy}, 32'h0);
    check("t5_rst_valid", {31'h0, a_valid}, 32'h0);
    rx_a = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(20);
    check("t5_no_pulse", a_vcnt + a_ecnt, v0 + e0);
    send_frame(1'b0, 8'h5A, 1'b1, 16);
    idle(20);
    check("t5_vcnt", a_vcnt, v0 + 1);
    check("t5_data", {24'h0, a_data}, 32'h5A);
    check("t5_ecnt", a_ecnt, e0);

    check("excl_consec", excl_viol, 0);

    // 6: default parameters, full-rate 0x55 frame
    send_frame(1'b1, 8'h55, 1'b1, 434);
    idle(500);
    check("t6_vcnt", b_vcnt, 1);
    check("t6_ecnt", b_ecnt, 0);
    check("t6_data", {24'h0, b_data}, 32'h55);
    check("t6_last", {24'h0, b_last}, 32'h55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
